// File: rtl/dmem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : dmem_arbiter                                                     |
// | Brief   : Shares the data-memory port between the CPU MEM stage and a      |
// |           debug/loader port; DBG uses idle slots or forces one on starve.  |
// | Option  : DMEM_ARB_PERF_EN adds perf_dbg_slots / perf_cpu_stalls counters. |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module dmem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [2:0]        cpu_ctrl,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_wr,
  input  logic [2:0]        dbg_ctrl,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wr,
  output logic [2:0]        mem_ctrl,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0]       perf_dbg_slots,
  output logic [31:0]       perf_cpu_stalls
`endif
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  typedef enum logic [0:0] {
    CPU_OWN = 1'b0,
    DBG_ACC = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] starve_cnt, starve_nxt;
  logic             dbg_slot;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= CPU_OWN;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  // starve_cnt only counts cycles where both sides want the port.
  always_comb begin
    state_nxt  = state;
    starve_nxt = starve_cnt;
    case (state)
      CPU_OWN: begin
        if (dbg_req && (!cpu_req || starve_cnt >= STARVE_LIM)) begin
          state_nxt  = DBG_ACC;
          starve_nxt = '0;
        end else if (dbg_req) begin
          if (starve_cnt < STARVE_LIM) starve_nxt = starve_cnt + CNT_W'(1);
        end else begin
          starve_nxt = '0;
        end
      end
      DBG_ACC: begin
        state_nxt  = CPU_OWN;
        starve_nxt = '0;
      end
      default: begin
        state_nxt  = CPU_OWN;
        starve_nxt = '0;
      end
    endcase
  end

  assign dbg_slot  = (state == DBG_ACC);
  assign dbg_gnt   = rst_n & dbg_slot & dbg_req;
  assign cpu_stall = rst_n & dbg_slot & cpu_req;
  assign cpu_rdata = mem_rdata;

  always_comb begin
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_ctrl  = cpu_ctrl;
    mem_wr    = cpu_req & cpu_wr;
    if (dbg_slot) begin
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
      mem_ctrl  = dbg_ctrl;
      mem_wr    = dbg_req & dbg_wr;
    end
    if (!rst_n) mem_wr = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dbg_rvalid <= 1'b0;
      dbg_rdata  <= '0;
    end else begin
      dbg_rvalid <= dbg_gnt & ~dbg_wr;
      if (dbg_gnt && !dbg_wr) dbg_rdata <= mem_rdata;
    end
  end

`ifdef DMEM_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_dbg_slots  <= '0;
      perf_cpu_stalls <= '0;
    end else begin
      perf_dbg_slots  <= perf_dbg_slots + {31'd0, dbg_gnt};
      perf_cpu_stalls <= perf_cpu_stalls + {31'd0, cpu_stall};
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_dmem_arbiter                                                  |
// | Brief   : Directed + random bench for dmem_arbiter against a slot model.   |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_dmem_arbiter;
  localparam int ADDR_W = 32, DATA_W = 32, STARVE_MAX = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, cpu_req, cpu_wr, dbg_req, dbg_wr;
  logic [2:0] cpu_ctrl, dbg_ctrl, mem_ctrl;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata, dbg_addr, dbg_wdata, dbg_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic cpu_stall, dbg_gnt, dbg_rvalid, mem_wr;
`ifdef DMEM_ARB_PERF_EN
  logic [31:0] perf_dbg_slots, perf_cpu_stalls;
`endif

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_ctrl(cpu_ctrl), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_wr(dbg_wr), .dbg_ctrl(dbg_ctrl), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr), .mem_ctrl(mem_ctrl),
    .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_PERF_EN
    , .perf_dbg_slots(perf_dbg_slots), .perf_cpu_stalls(perf_cpu_stalls)
`endif
  );

  // Environment memory: 64 words, combinational read, written on posedge.
  logic [31:0] env_mem [64];
  bit          env_init = 1'b0;
  assign mem_rdata = env_mem[mem_addr[7:2]];
  always @(posedge clk) begin
    if (!env_init) begin
      for (int i = 0; i < 64; i++) env_mem[i] <= 32'h0101_0101 * i;
    end else if (mem_wr) begin
      env_mem[mem_addr[7:2]] <= mem_wdata;
    end
  end

  // Reference model: does DBG own the current cycle, and how long has it waited.
  logic [31:0] ref_mem [64];
  bit          m_slot;
  int          m_wait;
  bit          m_rvalid;
  logic [31:0] m_rdata;
  int          m_slots, m_stalls;
  bit          reg_chk;
  bit          obs_gnt, obs_stall, obs_wr, obs_rvalid;
  logic [31:0] obs_rdata;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic step(input bit rn, input bit cr, input bit cw, input logic [31:0] ca,
                      input logic [31:0] cwd, input bit dr, input bit dw,
                      input logic [31:0] da, input logic [31:0] dwd);
    bit e_gnt, e_stall, e_wr;
    logic [31:0] e_addr, e_wdata;
    logic [2:0]  e_ctrl;
    rst_n = rn; cpu_req = cr; cpu_wr = cw; cpu_addr = ca; cpu_wdata = cwd;
    cpu_ctrl = 3'($urandom_range(0, 7)); dbg_ctrl = 3'($urandom_range(0, 7));
    dbg_req = dr; dbg_wr = dw; dbg_addr = da; dbg_wdata = dwd;
    e_gnt   = rn && m_slot && dr;
    e_stall = rn && m_slot && cr;
    e_wr    = rn && (m_slot ? (dr && dw) : (cr && cw));
    e_addr  = m_slot ? da : ca;
    e_wdata = m_slot ? dwd : cwd;
    e_ctrl  = m_slot ? dbg_ctrl : cpu_ctrl;
    #4;
    obs_gnt = dbg_gnt; obs_stall = cpu_stall; obs_wr = mem_wr;
    obs_rvalid = dbg_rvalid; obs_rdata = dbg_rdata;
    if (reg_chk) begin
      chk("dbg_rvalid", dbg_rvalid, m_rvalid);
      chk("dbg_rdata", dbg_rdata, m_rdata);
`ifdef DMEM_ARB_PERF_EN
      chk("perf_dbg_slots", perf_dbg_slots, 32'(m_slots));
      chk("perf_cpu_stalls", perf_cpu_stalls, 32'(m_stalls));
`endif
    end
    chk("dbg_gnt", dbg_gnt, e_gnt);
    chk("cpu_stall", cpu_stall, e_stall);
    chk("mem_wr", mem_wr, e_wr);
    if (rn) begin
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_ctrl", mem_ctrl, e_ctrl);
      if (e_wr) chk("mem_wdata", mem_wdata, e_wdata);
      chk("cpu_rdata", cpu_rdata, ref_mem[e_addr[7:2]]);
    end
    @(posedge clk);
    reg_chk = 1'b1;
    if (!rn) begin
      m_slot = 0; m_wait = 0; m_rvalid = 0; m_rdata = '0; m_slots = 0; m_stalls = 0;
    end else begin
      m_rvalid = e_gnt && !dw;
      if (m_rvalid) m_rdata = ref_mem[da[7:2]];
      if (e_wr) ref_mem[e_addr[7:2]] = e_wdata;
      m_slots  += int'(e_gnt);
      m_stalls += int'(e_stall);
      if (m_slot) begin
        m_slot = 0; m_wait = 0;
      end else if (dr) begin
        if (!cr || m_wait >= STARVE_MAX) begin
          m_slot = 1; m_wait = 0;
        end else begin
          m_wait++;
        end
      end else begin
        m_wait = 0;
      end
    end
    #1;
  endtask

  task automatic idle();
    step(1, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
  endtask

  function automatic logic [31:0] raddr();
    return {24'd0, 6'($urandom_range(0, 63)), 2'b00};
  endfunction

  initial begin
    int gnt_cyc, stalls, grants, wr_even;
    logic [9:0] gmask;
    bit dr, dw;
    logic [31:0] da, dwd;
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0101_0101 * i;
    m_slot = 0; m_wait = 0; m_rvalid = 0; m_rdata = '0; m_slots = 0; m_stalls = 0;
    reg_chk = 0;
    rst_n = 0; cpu_req = 0; cpu_wr = 0; dbg_req = 0; dbg_wr = 0;
    cpu_ctrl = '0; dbg_ctrl = '0; cpu_addr = '0; dbg_addr = '0; cpu_wdata = '0; dbg_wdata = '0;
    @(posedge clk); #1;
    env_init = 1'b1;

    // Reset with random inputs
    for (int i = 0; i < 2; i++)
      step(0, 1'($urandom), 1'($urandom), raddr(), $urandom, 1'($urandom), 1'($urandom), raddr(), $urandom);
    idle();
    chk("rst_rvalid", obs_rvalid, 1'b0);
    chk("rst_rdata", obs_rdata, 32'h0);

    // Idle DBG write then read
    step(1, 0, 0, 32'h0, 32'h0, 1, 1, 32'h10, 32'hDEADBEEF);
    chk("wr_gnt_c0", obs_gnt, 1'b0);
    step(1, 0, 0, 32'h0, 32'h0, 1, 1, 32'h10, 32'hDEADBEEF);
    chk("wr_gnt_c1", obs_gnt, 1'b1);
    chk("wr_memwr_c1", obs_wr, 1'b1);
    idle();
    step(1, 0, 0, 32'h0, 32'h0, 1, 0, 32'h10, 32'h0);
    step(1, 0, 0, 32'h0, 32'h0, 1, 0, 32'h10, 32'h0);
    chk("rd_gnt", obs_gnt, 1'b1);
    idle();
    chk("rd_rvalid", obs_rvalid, 1'b1);
    chk("rd_rdata", obs_rdata, 32'hDEADBEEF);
    idle();
    chk("rd_rvalid_pulse", obs_rvalid, 1'b0);

    // Contention: CPU busy every cycle
    gnt_cyc = -1; stalls = 0; dr = 1;
    for (int c = 0; c <= 10; c++) begin
      step(1, 1, 1'($urandom), raddr(), $urandom, dr, 1, raddr(), $urandom);
      if (obs_gnt && gnt_cyc < 0) gnt_cyc = c;
      if (obs_stall) stalls++;
      if (obs_gnt) dr = 0;
    end
    chk("cont_gnt_cycle", 64'(gnt_cyc), 64'(STARVE_MAX + 1));
    chk("cont_stall_count", 64'(stalls), 64'd1);
    idle();

    // Streaming writes with idle CPU
    grants = 0; wr_even = 0; gmask = '0;
    for (int c = 0; c < 10; c++) begin
      step(1, 0, 0, 32'h0, 32'h0, 1, 1, raddr(), $urandom);
      gmask[c] = obs_gnt;
      if (obs_gnt) grants++;
      if (obs_wr && (c % 2 == 0)) wr_even++;
    end
    chk("stream_grants", 64'(grants), 64'd5);
    chk("stream_mask", gmask, 10'h2AA);
    chk("stream_wr_even", 64'(wr_even), 64'd0);
    idle();

    // Abort a DBG read with reset
    step(1, 0, 0, 32'h0, 32'h0, 1, 0, 32'h20, 32'h0);
    step(0, 0, 0, 32'h0, 32'h0, 1, 0, 32'h20, 32'h0);
    step(1, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    chk("abort_rvalid", obs_rvalid, 1'b0);
    step(1, 0, 0, 32'h0, 32'h0, 1, 0, 32'h24, 32'h0);
    chk("abort_gnt_c0", obs_gnt, 1'b0);
    step(1, 0, 0, 32'h0, 32'h0, 1, 0, 32'h24, 32'h0);
    chk("abort_gnt_c1", obs_gnt, 1'b1);
    idle();

    // Withdraw request inside the DBG slot
    step(1, 0, 0, 32'h0, 32'h0, 1, 1, 32'h30, 32'hCAFEF00D);
    step(1, 0, 0, 32'h0, 32'h0, 0, 1, 32'h30, 32'hCAFEF00D);
    chk("wd_memwr", obs_wr, 1'b0);
    chk("wd_gnt", obs_gnt, 1'b0);
    idle();
    chk("wd_rvalid", obs_rvalid, 1'b0);
    chk("wd_mem", env_mem[12], ref_mem[12]);

    // Random traffic; DBG mostly holds its request until granted
    dr = 0; dw = 0; da = '0; dwd = '0;
    for (int n = 0; n < 3000; n++) begin
      if (dr && !obs_gnt && $urandom_range(0, 9) != 0) begin
      end else begin
        dr = 1'($urandom); dw = 1'($urandom); da = raddr(); dwd = $urandom;
      end
      step(($urandom_range(0, 63) != 0), ($urandom_range(0, 3) != 0), 1'($urandom),
           raddr(), $urandom, dr, dw, da, dwd);
    end
    for (int i = 0; i < 64; i++) chk("final_mem", env_mem[i], ref_mem[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
